// File: rtl/framebuffer_writer_pkg.sv
// Shared framebuffer geometry, FSM state type and pixel address helper.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package framebuffer_writer_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int FB_DEPTH  = SCREEN_W * SCREEN_H;
   localparam int FB_ADDR_W = 15;
   localparam int COLOUR_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_CLEAR,
      ST_DONE
   } fbw_state_t;

   // x + 160*y as shift-add; 15 bits holds even the largest out-of-range sum.
   function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
      return FB_ADDR_W'(x) + (FB_ADDR_W'(y) << 7) + (FB_ADDR_W'(y) << 5);
   endfunction

endpackage

// File: rtl/framebuffer_writer_pixel_addr_calc.sv
// Registers a pixel (x, y, colour) and presents its linear address and on-screen flag.
// Latency: 1 cycle from in_vld to out_vld; address is combinational from the registered x,y.
// Backpressure: none; accepts one pixel every cycle, caller gates in_vld.
module framebuffer_writer_pixel_addr_calc #(
   parameter int WIDTH    = framebuffer_writer_pkg::SCREEN_W,
   parameter int HEIGHT   = framebuffer_writer_pkg::SCREEN_H,
   parameter int ADDR_W   = framebuffer_writer_pkg::FB_ADDR_W,
   parameter int COLOUR_W = framebuffer_writer_pkg::COLOUR_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_vld,
   input  logic [7:0]          x,
   input  logic [6:0]          y,
   input  logic [COLOUR_W-1:0] colour,
   output logic                out_vld,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [COLOUR_W-1:0] out_colour,
   output logic                out_in_range
);
   import framebuffer_writer_pkg::*;

   localparam logic [7:0] X_LIM = 8'(WIDTH);
   localparam logic [6:0] Y_LIM = 7'(HEIGHT);

   logic [7:0] x_q;
   logic [6:0] y_q;

   // Stage 1 capture: coordinates, colour and the clip decision for the pixel.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_vld      <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         out_colour   <= '0;
         out_in_range <= 1'b0;
      end else begin
         out_vld <= in_vld;
         if (in_vld) begin
            x_q          <= x;
            y_q          <= y;
            out_colour   <= colour;
            out_in_range <= (x < X_LIM) && (y < Y_LIM);
         end
      end
   end

   assign out_addr = ADDR_W'(pixel_addr(x_q, y_q));

endmodule

// File: rtl/framebuffer_writer.sv
// Commits plotted pixels to the framebuffer RAM write port and runs a clear-screen sweep.
// Latency: accepted plot -> fb_wren 2 cycles later; clear takes 2 drain + 19200 write + 1 done cycles.
// Backpressure: ready drops whenever clear is requested or a clear is in progress.
module framebuffer_writer #(
   parameter int WIDTH    = framebuffer_writer_pkg::SCREEN_W,
   parameter int HEIGHT   = framebuffer_writer_pkg::SCREEN_H,
   parameter int ADDR_W   = framebuffer_writer_pkg::FB_ADDR_W,
   parameter int COLOUR_W = framebuffer_writer_pkg::COLOUR_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                plot,
   input  logic [7:0]          vga_x,
   input  logic [6:0]          vga_y,
   input  logic [COLOUR_W-1:0] colour,
   output logic                ready,
   input  logic                clear,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                done,
   output logic                busy,
   output logic [ADDR_W-1:0]   fb_address,
   output logic [COLOUR_W-1:0] fb_data,
   output logic                fb_wren,
   output logic [7:0]          clip_count
);
   import framebuffer_writer_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   fbw_state_t          state, state_nxt;
   logic                drain_cnt, drain_cnt_nxt;
   logic [COLOUR_W-1:0] clr_colour_q, clr_colour_nxt;
   logic                accept;

   logic                s1_vld;
   logic [ADDR_W-1:0]   s1_addr;
   logic [COLOUR_W-1:0] s1_colour;
   logic                s1_in_range;

   logic [ADDR_W-1:0]   addr_nxt;
   logic [COLOUR_W-1:0] data_nxt;
   logic                wren_nxt;

   framebuffer_writer_pixel_addr_calc #(
      .WIDTH    (WIDTH),
      .HEIGHT   (HEIGHT),
      .ADDR_W   (ADDR_W),
      .COLOUR_W (COLOUR_W)
   ) u_addr_calc (
      .clock        (clock),
      .reset        (reset),
      .in_vld       (accept),
      .x            (vga_x),
      .y            (vga_y),
      .colour       (colour),
      .out_vld      (s1_vld),
      .out_addr     (s1_addr),
      .out_colour   (s1_colour),
      .out_in_range (s1_in_range)
   );

   // Next state, handshake outputs and next write-port values; fb_address doubles as the sweep counter.
   always_comb begin
      state_nxt      = state;
      drain_cnt_nxt  = drain_cnt;
      clr_colour_nxt = clr_colour_q;
      addr_nxt       = fb_address;
      data_nxt       = fb_data;
      wren_nxt       = 1'b0;
      ready          = (state == ST_IDLE) && !clear;
      accept         = plot && ready;
      busy           = (state != ST_IDLE);
      done           = (state == ST_DONE);

      // Plot pipeline stage 2: only on-screen pixels raise the write enable.
      if (s1_vld) begin
         addr_nxt = s1_addr;
         data_nxt = s1_colour;
         wren_nxt = s1_in_range;
      end

      case (state)
         ST_IDLE: begin
            if (clear) begin
               state_nxt      = ST_DRAIN;
               drain_cnt_nxt  = 1'b0;
               clr_colour_nxt = clear_colour;
            end
         end
         ST_DRAIN: begin
            // Two cycles let the last accepted plot reach the RAM before the sweep starts.
            if (drain_cnt) begin
               state_nxt = ST_CLEAR;
               addr_nxt  = '0;
               data_nxt  = clr_colour_q;
               wren_nxt  = 1'b1;
            end else begin
               drain_cnt_nxt = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (fb_address == LAST_ADDR) begin
               state_nxt = ST_DONE;
               wren_nxt  = 1'b0;
            end else begin
               addr_nxt = fb_address + ADDR_W'(1);
               data_nxt = clr_colour_q;
               wren_nxt = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state, drain counter and captured fill colour.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         drain_cnt    <= 1'b0;
         clr_colour_q <= '0;
      end else begin
         state        <= state_nxt;
         drain_cnt    <= drain_cnt_nxt;
         clr_colour_q <= clr_colour_nxt;
      end
   end

   // Registered RAM write port.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fb_address <= '0;
         fb_data    <= '0;
         fb_wren    <= 1'b0;
      end else begin
         fb_address <= addr_nxt;
         fb_data    <= data_nxt;
         fb_wren    <= wren_nxt;
      end
   end

   // Saturating count of accepted plots that fell off-screen.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clip_count <= '0;
      end else if (s1_vld && !s1_in_range && (clip_count != 8'hFF)) begin
         clip_count <= clip_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer with a write scoreboard.
// Latency: expected writes are queued at stimulus time and popped as fb_wren pulses appear.
// Backpressure: checks ready stays low across every clear window.
module tb_framebuffer_writer;

   typedef struct packed {
      logic [14:0] addr;
      logic [2:0]  data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        plot;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  colour;
   logic        ready;
   logic        clear;
   logic [2:0]  clear_colour;
   logic        done;
   logic        busy;
   logic [14:0] fb_address;
   logic [2:0]  fb_data;
   logic        fb_wren;
   logic [7:0]  clip_count;

   wr_t sb[$];
   wr_t mon_e;
   int  vectors = 0;
   int  miscompares = 0;

   framebuffer_writer dut (
      .clock        (clock),
      .reset        (reset),
      .plot         (plot),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .colour       (colour),
      .ready        (ready),
      .clear        (clear),
      .clear_colour (clear_colour),
      .done         (done),
      .busy         (busy),
      .fb_address   (fb_address),
      .fb_data      (fb_data),
      .fb_wren      (fb_wren),
      .clip_count   (clip_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_px(input logic p, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      plot   = p;
      vga_x  = x;
      vga_y  = y;
      colour = c;
   endtask

   task automatic push_wr(input int a, input logic [2:0] d);
      sb.push_back('{addr: 15'(a), data: d});
   endtask

   task automatic push_clear(input logic [2:0] c);
      for (int i = 0; i < 19200; i++) push_wr(i, c);
   endtask

   // Every RAM write must match the head of the scoreboard, in order.
   always @(negedge clock) begin
      if (!reset && fb_wren) begin
         check("write_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("write_addr", 32'(fb_address), 32'(mon_e.addr));
            check("write_data", 32'(fb_data), 32'(mon_e.data));
         end
      end
   end

   initial begin
      int busy_cyc;
      int done_cyc;
      int rdy_hi;
      bit fin;

      reset = 1'b1;
      clear = 1'b0;
      clear_colour = '0;
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      repeat (3) @(negedge clock);
      check("rst_wren", 32'(fb_wren), 0);
      check("rst_addr", 32'(fb_address), 0);
      check("rst_data", 32'(fb_data), 0);
      check("rst_done", 32'(done), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_clip", 32'(clip_count), 0);
      reset = 1'b0;
      #1 check("rst_ready", 32'(ready), 1);

      // single plot (5,3) colour 6 -> address 485 two cycles later
      @(negedge clock);
      set_px(1'b1, 8'd5, 7'd3, 3'd6);
      push_wr(485, 3'd6);
      @(negedge clock);
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      check("single_n1_wren", 32'(fb_wren), 0);
      @(negedge clock);
      check("single_n2_wren", 32'(fb_wren), 1);
      check("single_n2_addr", 32'(fb_address), 485);
      check("single_n2_data", 32'(fb_data), 6);
      @(negedge clock);
      check("single_n3_wren", 32'(fb_wren), 0);

      // corners back-to-back
      @(negedge clock);
      set_px(1'b1, 8'd0, 7'd0, 3'd1);
      push_wr(0, 3'd1);
      @(negedge clock);
      set_px(1'b1, 8'd159, 7'd119, 3'd2);
      push_wr(19199, 3'd2);
      @(negedge clock);
      set_px(1'b1, 8'd159, 7'd0, 3'd3);
      push_wr(159, 3'd3);
      check("b2b_0_wren", 32'(fb_wren), 1);
      check("b2b_0_addr", 32'(fb_address), 0);
      @(negedge clock);
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      check("b2b_1_wren", 32'(fb_wren), 1);
      check("b2b_1_addr", 32'(fb_address), 19199);
      @(negedge clock);
      check("b2b_2_wren", 32'(fb_wren), 1);
      check("b2b_2_addr", 32'(fb_address), 159);
      @(negedge clock);
      check("b2b_end_wren", 32'(fb_wren), 0);

      // clipping: no writes expected, counter saturates
      @(negedge clock);
      set_px(1'b1, 8'd160, 7'd0, 3'd5);
      #1 check("clip_ready", 32'(ready), 1);
      @(negedge clock);
      set_px(1'b1, 8'd0, 7'd120, 3'd5);
      @(negedge clock);
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      repeat (3) @(negedge clock);
      check("clip_two", 32'(clip_count), 2);
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (i % 2 == 0)
            set_px(1'b1, 8'($urandom_range(160, 255)), 7'($urandom_range(0, 127)), 3'($urandom));
         else
            set_px(1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(120, 127)), 3'($urandom));
      end
      @(negedge clock);
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      repeat (3) @(negedge clock);
      check("clip_sat", 32'(clip_count), 255);

      // clear colour 2 with plot (10,10) in flight; plots hammered during the window
      @(negedge clock);
      set_px(1'b1, 8'd10, 7'd10, 3'd5);
      push_wr(1610, 3'd5);
      @(negedge clock);
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      clear = 1'b1;
      clear_colour = 3'd2;
      push_clear(3'd2);
      #1 check("clear_req_ready", 32'(ready), 0);
      @(negedge clock);
      clear = 1'b0;
      busy_cyc = 0;
      done_cyc = 0;
      rdy_hi = 0;
      fin = 1'b0;
      set_px(1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom));
      for (int k = 0; k < 20000; k++) begin
         if (busy) begin
            busy_cyc++;
            if (ready) rdy_hi++;
            if (done) done_cyc++;
            set_px(1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom));
         end else if (busy_cyc > 0 || k > 0) begin
            set_px(1'b0, 8'd0, 7'd0, 3'd0);
            fin = 1'b1;
            break;
         end
         @(negedge clock);
      end
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      check("clear_finished", 32'(fin), 1);
      check("clear_busy_cycles", 32'(busy_cyc), 19203);
      check("clear_done_pulses", 32'(done_cyc), 1);
      check("clear_ready_high", 32'(rdy_hi), 0);
      repeat (2) @(negedge clock);
      check("clear_sb_empty", 32'(sb.size()), 0);

      // same-cycle clear and plot: plot dropped, clear proceeds
      @(negedge clock);
      set_px(1'b1, 8'd1, 7'd1, 3'd7);
      clear = 1'b1;
      clear_colour = 3'd4;
      push_clear(3'd4);
      #1 check("both_ready", 32'(ready), 0);
      @(negedge clock);
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      clear = 1'b0;
      fin = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clock);
         if (done) begin
            fin = 1'b1;
            break;
         end
      end
      check("both_done_seen", 32'(fin), 1);
      repeat (2) @(negedge clock);
      check("both_sb_empty", 32'(sb.size()), 0);
      check("both_busy_end", 32'(busy), 0);

      // reset in the middle of a sweep at address 5000
      @(negedge clock);
      clear = 1'b1;
      clear_colour = 3'd7;
      push_clear(3'd7);
      @(negedge clock);
      clear = 1'b0;
      fin = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clock);
         if (fb_wren && fb_address == 15'd5000) begin
            fin = 1'b1;
            break;
         end
      end
      check("midclr_reached_5000", 32'(fin), 1);
      #2 reset = 1'b1;
      sb.delete();
      #1;
      check("midclr_rst_wren", 32'(fb_wren), 0);
      check("midclr_rst_busy", 32'(busy), 0);
      check("midclr_rst_addr", 32'(fb_address), 0);
      check("midclr_rst_clip", 32'(clip_count), 0);
      @(negedge clock);
      reset = 1'b0;
      #1 check("midclr_ready", 32'(ready), 1);
      set_px(1'b1, 8'd20, 7'd100, 3'd1);
      push_wr(16020, 3'd1);
      @(negedge clock);
      set_px(1'b0, 8'd0, 7'd0, 3'd0);
      @(negedge clock);
      check("post_rst_wren", 32'(fb_wren), 1);
      check("post_rst_addr", 32'(fb_address), 16020);
      repeat (3) @(negedge clock);
      check("post_rst_busy", 32'(busy), 0);
      check("final_sb_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
